// File: rtl/seq_mul_periph.sv
// seq_mul_periph
//   Memory-mapped shift-add multiplier on the picorv32 look-ahead bus.
//   Firmware loads A and B, writes CTRL bit0 to start, polls STATUS, and
//   reads the 2N-bit product from RES_LO/RES_HI. One multiplier bit is
//   retired per clock, so the product is ready N cycles after the start.
//
//   Register map (byte offsets from BASE):
//     0x00 A (R/W)   0x04 B (R/W)   0x08 CTRL(W)/STATUS(R)
//     0x0C RES_LO (R)   0x10 RES_HI (R)
//
//   Ports:
//     clk, reset                  system clock, synchronous active-high reset
//     la_read/la_write            look-ahead read/write strobes
//     la_addr/la_wdata/la_wstrb   look-ahead address, write data, byte strobes
//     rdata, rd_hit               registered read data and its one-cycle hit flag
//     busy, done                  multiply in progress / sticky completion
//
//   Build option: define SEQ_MUL_SIGNED_EN to treat A and B as two's
//   complement. Magnitudes are multiplied and one extra cycle negates the
//   result when the operand signs differ.
module seq_mul_periph #(
    parameter int          N    = 32,
    parameter logic [31:0] BASE = 32'h0FFF_FFE0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        la_read,
    input  logic        la_write,
    input  logic [31:0] la_addr,
    input  logic [31:0] la_wdata,
    input  logic [3:0]  la_wstrb,
    output logic [31:0] rdata,
    output logic        rd_hit,
    output logic        busy,
    output logic        done
);
    localparam int CW = $clog2(N + 1);

    localparam logic [31:0] ADDR_A    = BASE + 32'h00;
    localparam logic [31:0] ADDR_B    = BASE + 32'h04;
    localparam logic [31:0] ADDR_CTRL = BASE + 32'h08;
    localparam logic [31:0] ADDR_RLO  = BASE + 32'h0C;
    localparam logic [31:0] ADDR_RHI  = BASE + 32'h10;

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_NEG} state_t;

    state_t          state_q;
    logic [N-1:0]    a_q, b_q;
    logic [2*N-1:0]  m_q;       // multiplicand, shifted left each step
    logic [N-1:0]    q_q;       // multiplier, shifted right each step
    logic [2*N-1:0]  p_q;       // accumulator
    logic [CW-1:0]   cnt_q;
    logic [2*N-1:0]  res_q;
    logic            sgn_q;
    logic            busy_q, done_q;
    logic [31:0]     rdata_q;
    logic            rd_hit_q;

    logic            wr_ok;
    logic            rd_sel_d;
    logic [31:0]     rd_val_d;
    logic [2*N-1:0]  p_d;
    logic [N-1:0]    a_mag_d, b_mag_d;
    logic            sgn_d;

    assign rdata  = rdata_q;
    assign rd_hit = rd_hit_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Partial byte writes are not meaningful for these word registers.
    assign wr_ok = la_write && (la_wstrb == 4'hF);

    // Accumulator value after this cycle's step.
    assign p_d = q_q[0] ? (p_q + m_q) : p_q;

`ifdef SEQ_MUL_SIGNED_EN
    // Negating 0x8000_0000 wraps back to itself, which read unsigned is
    // exactly the magnitude 2^31.
    assign a_mag_d = a_q[N-1] ? (~a_q + N'(1)) : a_q;
    assign b_mag_d = b_q[N-1] ? (~b_q + N'(1)) : b_q;
    assign sgn_d   = a_q[N-1] ^ b_q[N-1];
`else
    assign a_mag_d = a_q;
    assign b_mag_d = b_q;
    assign sgn_d   = 1'b0;
`endif

    always_comb begin
        rd_sel_d = 1'b0;
        rd_val_d = '0;
        case (la_addr)
            ADDR_A:    begin rd_sel_d = 1'b1; rd_val_d = 32'(a_q); end
            ADDR_B:    begin rd_sel_d = 1'b1; rd_val_d = 32'(b_q); end
            ADDR_CTRL: begin rd_sel_d = 1'b1; rd_val_d = {30'b0, done_q, busy_q}; end
            ADDR_RLO:  begin rd_sel_d = 1'b1; rd_val_d = 32'(res_q[N-1:0]); end
            ADDR_RHI:  begin rd_sel_d = 1'b1; rd_val_d = 32'(res_q[2*N-1:N]); end
            default:   ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            q_q      <= '0;
            p_q      <= '0;
            cnt_q    <= '0;
            res_q    <= '0;
            sgn_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            rdata_q  <= '0;
            rd_hit_q <= 1'b0;
        end else begin
            // Reads see pre-edge register values; a concurrent write wins.
            rd_hit_q <= 1'b0;
            if (la_read && !la_write && rd_sel_d) begin
                rd_hit_q <= 1'b1;
                rdata_q  <= rd_val_d;
            end

            case (state_q)
                S_IDLE: begin
                    if (wr_ok) begin
                        case (la_addr)
                            ADDR_A: a_q <= la_wdata[N-1:0];
                            ADDR_B: b_q <= la_wdata[N-1:0];
                            ADDR_CTRL: begin
                                if (la_wdata[0]) begin
                                    m_q     <= {{N{1'b0}}, a_mag_d};
                                    q_q     <= b_mag_d;
                                    p_q     <= '0;
                                    sgn_q   <= sgn_d;
                                    cnt_q   <= CW'(N);
                                    done_q  <= 1'b0;
                                    busy_q  <= 1'b1;
                                    state_q <= S_BUSY;
                                end else if (la_wdata[1]) begin
                                    done_q <= 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
                S_BUSY: begin
                    p_q   <= p_d;
                    m_q   <= m_q << 1;
                    q_q   <= q_q >> 1;
                    cnt_q <= cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
`ifdef SEQ_MUL_SIGNED_EN
                        state_q <= S_NEG;
`else
                        res_q   <= p_d;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= S_IDLE;
`endif
                    end
                end
                S_NEG: begin
                    res_q   <= sgn_q ? (~p_q + (2*N)'(1)) : p_q;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_mul_periph.sv
module tb_seq_mul_periph;
    localparam logic [31:0] BASE = 32'h0FFF_FFE0;
`ifdef SEQ_MUL_SIGNED_EN
    localparam int LAT = 33;
`else
    localparam int LAT = 32;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        la_read = 1'b0, la_write = 1'b0;
    logic [31:0] la_addr = '0, la_wdata = '0;
    logic [3:0]  la_wstrb = '0;
    logic [31:0] rdata;
    logic        rd_hit, busy, done;

    seq_mul_periph dut (
        .clk(clk), .reset(reset), .la_read(la_read), .la_write(la_write),
        .la_addr(la_addr), .la_wdata(la_wdata), .la_wstrb(la_wstrb),
        .rdata(rdata), .rd_hit(rd_hit), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    typedef struct { int cyc; logic [31:0] data; } exp_t;
    exp_t rq[$];

    // Reference model: register file plus a countdown of busy cycles.
    logic [31:0] m_a = '0, m_b = '0;
    logic [63:0] m_res = '0, m_pend = '0;
    bit          m_done = 1'b0;
    int          m_left = 0;

    int checks = 0, passes = 0;

    function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc_cnt);
    endfunction

    function automatic logic [63:0] prod(input logic [31:0] a, input logic [31:0] b);
`ifdef SEQ_MUL_SIGNED_EN
        logic signed [63:0] sa, sb;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        return sa * sb;
`else
        return {32'b0, a} * {32'b0, b};
`endif
    endfunction

    function automatic bit model_read(input logic [31:0] addr, output logic [31:0] v);
        v = '0;
        case (addr)
            BASE + 32'h00: v = m_a;
            BASE + 32'h04: v = m_b;
            BASE + 32'h08: v = {30'b0, m_done, m_left > 0};
            BASE + 32'h0C: v = m_res[31:0];
            BASE + 32'h10: v = m_res[63:32];
            default: return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // One bus cycle: drive, predict, clock, update the model.
    task automatic cyc(input bit rst, input bit rd, input bit wr, input logic [31:0] addr,
                       input logic [31:0] data, input logic [3:0] strb);
        logic [31:0] v;
        exp_t e;
        reset = rst; la_read = rd; la_write = wr; la_addr = addr; la_wdata = data; la_wstrb = strb;
        if (!rst && rd && !wr && model_read(addr, v)) begin
            e.cyc = cyc_cnt + 1; e.data = v;
            rq.push_back(e);
        end
        @(posedge clk);
        if (rst) begin
            m_a = '0; m_b = '0; m_res = '0; m_done = 1'b0; m_left = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0) begin m_res = m_pend; m_done = 1'b1; end
        end else if (wr && strb == 4'hF) begin
            if (addr == BASE)               m_a = data;
            else if (addr == BASE + 32'h04) m_b = data;
            else if (addr == BASE + 32'h08) begin
                if (data[0]) begin
                    m_pend = prod(m_a, m_b); m_left = LAT; m_done = 1'b0;
                end else if (data[1]) m_done = 1'b0;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, '0, '0, 4'h0);
    endtask
    task automatic rd(input logic [31:0] off);
        cyc(0, 1, 0, BASE + off, '0, 4'h0);
    endtask
    task automatic wr(input logic [31:0] off, input logic [31:0] d);
        cyc(0, 0, 1, BASE + off, d, 4'hF);
    endtask
    task automatic mul(input logic [31:0] a, input logic [31:0] b);
        wr(0, a); wr(4, b); wr(8, 1);
        idle(LAT + 1);
        rd(8'h0C); rd(8'h10); rd(8'h08);
    endtask

    // Monitor: pops the scoreboard whenever the DUT presents a read.
    always @(negedge clk) begin
        if (rd_hit) begin
            if (rq.size() == 0) chk("spurious_rd_hit", 64'(rd_hit), 64'(0));
            else begin
                exp_t e;
                e = rq.pop_front();
                chk("rd_latency", 64'(cyc_cnt), 64'(e.cyc));
                chk("rdata", 64'(rdata), 64'(e.data));
            end
        end else if (rq.size() > 0 && rq[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = rq.pop_front();
            chk("missing_rd_hit", 64'(rd_hit), 64'(1));
        end
        chk("busy", 64'(busy), 64'(m_left > 0));
        chk("done", 64'(done), 64'(m_done));
    end

    initial begin
        cyc(1, 0, 0, '0, '0, 4'h0);
        cyc(1, 0, 0, '0, '0, 4'h0);
        for (int i = 0; i < 5; i++) rd(32'(i * 4));
        mul(32'd3, 32'd5);
        mul(32'hFFFF_FFFF, 32'hFFFF_FFFF);
        mul(32'hFFFF_FFFE, 32'd3);
        mul(32'h8000_0000, 32'h8000_0000);

        // Writes while busy are dropped; the running product completes.
        wr(0, 32'd10); wr(4, 32'd11); wr(8, 1);
        idle(3); wr(0, 32'd7); wr(8, 1); rd(0); rd(8);
        idle(LAT); rd(0); rd(8'h0C); rd(8'h10); rd(8);
        wr(8, 2); rd(8);

        // Reset in the middle of a multiply.
        wr(0, 32'd9); wr(4, 32'd9); wr(8, 1);
        idle(9);
        cyc(1, 0, 0, '0, '0, 4'h0);
        rd(8'h0C); rd(8'h10); rd(8);
        mul(32'd2, 32'd2);

        // Undecoded addresses, partial strobes, simultaneous strobes.
        rd(8'h14); cyc(0, 1, 0, BASE + 1, '0, 4'h0); cyc(0, 1, 0, 32'h0, '0, 4'h0);
        cyc(0, 0, 1, BASE, 32'h1234, 4'h7); rd(0);
        cyc(0, 1, 1, BASE + 4, 32'h55, 4'hF); rd(4);

        // Random traffic, including bus activity while busy.
        for (int n = 0; n < 25; n++) begin
            logic [31:0] a, b;
            a = $urandom; b = $urandom;
            if (n % 5 == 0) a = 32'h8000_0000;
            if (n % 7 == 0) b = 32'hFFFF_FFFF;
            if (n % 6 == 1) a = 0;
            cyc(0, 0, 1, BASE, $urandom, ($urandom_range(0, 1) != 0) ? 4'hF : 4'h3);
            wr(0, a); wr(4, b); wr(8, 1);
            for (int i = 0; i < LAT + 3; i++) begin
                case ($urandom_range(0, 5))
                    0: rd(32'($urandom_range(0, 5) * 4));
                    1: wr(32'($urandom_range(0, 2) * 4), $urandom);
                    2: wr(8, 2);
                    default: idle(1);
                endcase
            end
            idle(LAT + 2);
            rd(8'h0C); rd(8'h10); rd(8); rd(0); rd(4);
        end

        idle(3);
        chk("scoreboard_drained", 64'(rq.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
